mask_index_sequencer: RTL and testbench



---
 rtl/mask_index_sequencer.sv | 108 ++++++++++
 tb/tb_mask_index_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mask_index_sequencer.sv
// rtl/mask_index_sequencer.sv - MSB-first set-bit index sequencer over valid/ready mask and index streams
// Optional MASK_SEQ_EMPTY_BEAT_EN: an all-zero mask yields one beat flagged on idx_empty_o.
module mask_index_sequencer #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             nreset_i,
   input  logic             flush_i,
   input  logic             mask_valid_i,
   output logic             mask_ready_o,
   input  logic [WIDTH-1:0] mask_i,
   output logic             idx_valid_o,
   input  logic             idx_ready_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             idx_last_o,
`ifdef MASK_SEQ_EMPTY_BEAT_EN
   output logic             idx_empty_o,
`endif
   output logic             busy_o
);

   localparam int LZ_W = IDX_W + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] top_bit;
   logic [LZ_W-1:0]  lz;
   logic             run;
   logic             single;
   logic             mask_hs;
   logic             idx_hs;
`ifdef MASK_SEQ_EMPTY_BEAT_EN
   logic             empty_q;
`endif

   // Leading-zero count; the extra MSB flags an all-zero input (result == WIDTH).
   function automatic logic [LZ_W-1:0] lzc(input logic [WIDTH-1:0] m);
      logic [LZ_W-1:0] n;
      n = LZ_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (m[i]) n = LZ_W'(WIDTH - 1 - i);
      end
      return n;
   endfunction

   assign lz = lzc(mask_q);

   always_comb begin
      top_bit = '0;
      for (int i = 0; i < WIDTH; i++) begin
         top_bit[i] = (lz == LZ_W'(WIDTH - 1 - i));
      end
   end

   assign run    = (state == RUN);
   assign single = (mask_q != '0) && ((mask_q & (mask_q - WIDTH'(1))) == '0);

   assign busy_o      = run;
   assign idx_valid_o = run;
   assign idx_o       = run ? lz[IDX_W-1:0] : '0;
`ifdef MASK_SEQ_EMPTY_BEAT_EN
   assign idx_last_o  = run & (single | empty_q);
   assign idx_empty_o = run & empty_q;
`else
   assign idx_last_o  = run & single;
`endif

   // Ready in RUN only on the final beat so the next mask chains in without a bubble.
   assign mask_ready_o = nreset_i & ~flush_i & (~run | (idx_ready_i & idx_last_o));
   assign mask_hs      = mask_valid_i & mask_ready_o;
   assign idx_hs       = run & idx_ready_i;

   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) begin
         state  <= IDLE;
         mask_q <= '0;
`ifdef MASK_SEQ_EMPTY_BEAT_EN
         empty_q <= 1'b0;
`endif
      end else if (flush_i) begin
         state  <= IDLE;
         mask_q <= '0;
`ifdef MASK_SEQ_EMPTY_BEAT_EN
         empty_q <= 1'b0;
`endif
      end else if (mask_hs) begin
         mask_q <= mask_i;
`ifdef MASK_SEQ_EMPTY_BEAT_EN
         state   <= RUN;
         empty_q <= (mask_i == '0);
`else
         state   <= (mask_i != '0) ? RUN : IDLE;
`endif
      end else if (idx_hs) begin
         mask_q <= mask_q & ~top_bit;
         if (idx_last_o) begin
            state <= IDLE;
`ifdef MASK_SEQ_EMPTY_BEAT_EN
            empty_q <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_mask_index_sequencer.sv
// tb/tb_mask_index_sequencer.sv - scoreboard bench for mask_index_sequencer (WIDTH 32 and WIDTH 8)
// Honours MASK_SEQ_EMPTY_BEAT_EN when defined.
module tb_mask_index_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         nreset = 1'b0;
   logic         flush = 1'b0;
   logic         mask_valid = 1'b0;
   logic         mask_ready;
   logic [W-1:0] mask_in = '0;
   logic         idx_valid;
   logic         idx_ready = 1'b0;
   logic [4:0]   idx;
   logic         idx_last;
   logic         busy;
   logic         idx_empty;

   logic         v8 = 1'b0;
   logic         ready8;
   logic [7:0]   m8 = '0;
   logic         valid8;
   logic         rdy8 = 1'b0;
   logic [2:0]   idx8;
   logic         last8;
   logic         busy8;
   logic         empty8;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int idx;
      bit last;
      bit empty;
   } beat_t;

   beat_t exp_q[$];

   always #5 clk = ~clk;

   mask_index_sequencer #(.WIDTH(32), .IDX_W(5)) dut (
      .clk          (clk),
      .nreset_i     (nreset),
      .flush_i      (flush),
      .mask_valid_i (mask_valid),
      .mask_ready_o (mask_ready),
      .mask_i       (mask_in),
      .idx_valid_o  (idx_valid),
      .idx_ready_i  (idx_ready),
      .idx_o        (idx),
      .idx_last_o   (idx_last),
`ifdef MASK_SEQ_EMPTY_BEAT_EN
      .idx_empty_o  (idx_empty),
`endif
      .busy_o       (busy)
   );

   mask_index_sequencer #(.WIDTH(8), .IDX_W(3)) dut8 (
      .clk          (clk),
      .nreset_i     (nreset),
      .flush_i      (1'b0),
      .mask_valid_i (v8),
      .mask_ready_o (ready8),
      .mask_i       (m8),
      .idx_valid_o  (valid8),
      .idx_ready_i  (rdy8),
      .idx_o        (idx8),
      .idx_last_o   (last8),
`ifdef MASK_SEQ_EMPTY_BEAT_EN
      .idx_empty_o  (empty8),
`endif
      .busy_o       (busy8)
   );

`ifndef MASK_SEQ_EMPTY_BEAT_EN
   assign idx_empty = 1'b0;
   assign empty8    = 1'b0;
`endif

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: one beat per set bit, highest bit first, distance from the MSB.
   task automatic push_beats(input logic [W-1:0] m);
      beat_t b;
      int n = 0;
      for (int p = W - 1; p >= 0; p--) begin
         if (m[p]) begin
            b.idx = W - 1 - p; b.last = 1'b0; b.empty = 1'b0;
            exp_q.push_back(b);
            n++;
         end
      end
      if (n > 0) exp_q[exp_q.size() - 1].last = 1'b1;
`ifdef MASK_SEQ_EMPTY_BEAT_EN
      else begin
         b.idx = 0; b.last = 1'b1; b.empty = 1'b1;
         exp_q.push_back(b);
      end
`endif
   endtask

   // Monitor: compare against the model state, then advance the model for the coming edge.
   always @(negedge clk) begin
      beat_t f;
      if (!nreset) begin
         check("rst_valid", idx_valid, 0);
         check("rst_ready", mask_ready, 0);
         check("rst_busy", busy, 0);
         check("rst_idx", idx, 0);
         check("rst_last", idx_last, 0);
         check("rst_empty", idx_empty, 0);
         exp_q.delete();
      end else begin
         check("busy", busy, exp_q.size() != 0);
         check("valid", idx_valid, exp_q.size() != 0);
         check("ready", mask_ready,
               !flush && (exp_q.size() == 0 || (idx_ready && exp_q.size() == 1)));
         if (idx_valid && exp_q.size() != 0) begin
            f = exp_q[0];
            check("idx", idx, f.idx);
            check("last", idx_last, f.last);
            check("empty", idx_empty, f.empty);
         end
         if (flush) begin
            exp_q.delete();
         end else begin
            if (idx_valid && idx_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (mask_valid && mask_ready) push_beats(mask_in);
         end
      end
   end

   task automatic drive(input bit v, input logic [W-1:0] m, input bit r, input bit f);
      mask_valid = v; mask_in = m; idx_ready = r; flush = f;
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] rand_mask();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return W'(1) << $urandom_range(0, W - 1);
         2:       return '1;
         default: return W'($urandom) & W'($urandom) & W'($urandom);
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 nreset = 1'b1;
      drive(0, '0, 1, 0);

      drive(1, 32'h8000_0001, 1, 0);
      repeat (3) drive(0, '0, 1, 0);

      drive(1, 32'h0000_0008, 0, 0);
      repeat (3) drive(0, '0, 0, 0);
      repeat (2) drive(0, '0, 1, 0);

      drive(1, 32'h0000_0003, 1, 0);
      drive(1, 32'h8000_0000, 1, 0);
      drive(1, 32'h8000_0000, 1, 0);
      repeat (2) drive(0, '0, 1, 0);

      drive(1, 32'h0, 1, 0);
      repeat (2) drive(0, '0, 1, 0);

      drive(1, 32'hFFFF_FFFF, 1, 0);
      repeat (3) drive(0, '0, 1, 0);
      drive(1, 32'hFFFF_FFFF, 1, 1);
      repeat (2) drive(0, '0, 1, 0);

      v8 = 1'b1; m8 = 8'h24; rdy8 = 1'b1;
      @(negedge clk) check("w8_ready", ready8, 1);
      @(posedge clk); #1 v8 = 1'b0;
      @(negedge clk);
      check("w8_valid0", valid8, 1);
      check("w8_idx0", idx8, 2);
      check("w8_last0", last8, 0);
      @(negedge clk);
      check("w8_idx1", idx8, 5);
      check("w8_last1", last8, 1);
      @(negedge clk);
      check("w8_idle", valid8, 0);
      check("w8_busy", busy8, 0);
      @(posedge clk); #1;

      v8 = 1'b1; m8 = 8'hFF; rdy8 = 1'b0;
      drive(1, 32'hF0F0_0000, 0, 0);
      v8 = 1'b0;
      drive(0, '0, 0, 0);
      #3 nreset = 1'b0;
      #1;
      check("arst_valid", idx_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_valid8", valid8, 0);
      repeat (2) @(posedge clk);
      #1 nreset = 1'b1;
      rdy8 = 1'b1;
      repeat (3) begin
         drive(0, '0, 1, 0);
         check("post_rst_valid8", valid8, 0);
      end

      repeat (3000) begin
         drive($urandom_range(0, 3) != 0, rand_mask(), $urandom_range(0, 3) != 0,
               $urandom_range(0, 29) == 0);
      end
      repeat (40) drive(0, '0, 1, 0);
      check("drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
